// File: rtl/net_infer_seq_pkg.sv
// Shared types and default constants for the logic-gate network sequencer.
package net_infer_seq_pkg;

   // Network geometry: 20x20 binarized image in, class index out.
   localparam int NET_INPUTS         = 400;
   localparam int NET_OUTPUT_BITS    = 4;

   // Sequencer defaults.
   localparam int NET_SETTLE_CYCLES  = 2;
   localparam int NET_RES_FIFO_DEPTH = 4;
   localparam int NET_TAG_W          = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2
   } seq_state_t;

   // Result entry at the default tag width; the sequencer re-declares it
   // locally when its tag width is overridden.
   typedef struct packed {
      logic [NET_TAG_W-1:0]       tag;
      logic [NET_OUTPUT_BITS-1:0] cls;
   } net_result_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/net_result_fifo.sv
// Small synchronous result FIFO with a combinational head view.
// Pointers carry one extra bit so full and empty are distinguishable.
module net_result_fifo
   import net_infer_seq_pkg::*;
#(
   parameter int  DEPTH = NET_RES_FIFO_DEPTH,
   parameter type T     = net_result_t
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   output T     head,
   output logic full,
   output logic empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   T           mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // A push into a full FIFO is legal only when the head leaves on the same edge.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem_q[rd_ptr_q[AW-1:0]];

   // Next pointer values; both wrap naturally through the extra bit.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // Pointer registers and storage; storage is cleared so the head reads zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/net_infer_seq.sv
// Sequencer around the combinational gate network: latch an image onto the
// network inputs, let it settle, capture the class with a sequence tag.
module net_infer_seq
   import net_infer_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = NET_SETTLE_CYCLES,
   parameter int FIFO_DEPTH    = NET_RES_FIFO_DEPTH,
   parameter int TAG_W         = NET_TAG_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NET_INPUTS-1:0]      in_data,
   output logic [NET_INPUTS-1:0]      net_i,
   input  logic [NET_OUTPUT_BITS-1:0] net_o,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NET_OUTPUT_BITS-1:0] out_data,
   output logic [TAG_W-1:0]           out_tag,
   output logic                       busy,
   output logic [31:0]                infer_count
);

   typedef struct packed {
      logic [TAG_W-1:0]           tag;
      logic [NET_OUTPUT_BITS-1:0] cls;
   } res_t;

   seq_state_t                state_q, state_d;
   logic [NET_INPUTS-1:0]     net_i_q, net_i_d;
   logic [7:0]                cnt_q, cnt_d;
   logic [TAG_W-1:0]          tag_q, tag_d;
   logic [31:0]               infer_count_q, infer_count_d;

   logic fifo_full;
   logic fifo_empty;
   logic pop;
   logic push_ok;
   logic push;
   res_t push_entry;
   res_t head;

   assign out_valid   = !fifo_empty;
   assign pop         = out_valid && out_ready;
   assign push_ok     = !fifo_full || pop;
   assign push        = (state_q == CAPTURE) && push_ok;
   assign push_entry  = '{tag: tag_q, cls: net_o};

   assign in_ready    = (state_q == IDLE);
   assign busy        = (state_q != IDLE) || !fifo_empty;
   assign net_i       = net_i_q;
   assign out_data    = head.cls;
   assign out_tag     = head.tag;
   assign infer_count = infer_count_q;

   // Next-state logic: accept in IDLE, count down in SETTLE, push when room in CAPTURE.
   always_comb begin
      state_d       = state_q;
      net_i_d       = net_i_q;
      cnt_d         = cnt_q;
      tag_d         = tag_q;
      infer_count_d = infer_count_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               net_i_d = in_data;
               cnt_d   = 8'(SETTLE_CYCLES - 1);
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == 8'd0) state_d = CAPTURE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         CAPTURE: begin
            // net_i stays put while stalled so the captured class stays valid.
            if (push_ok) begin
               tag_d         = tag_q + 1'b1;
               infer_count_d = sat_inc32(infer_count_q);
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer state, network drive, settle counter, tag and result counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         net_i_q       <= '0;
         cnt_q         <= '0;
         tag_q         <= '0;
         infer_count_q <= '0;
      end else begin
         state_q       <= state_d;
         net_i_q       <= net_i_d;
         cnt_q         <= cnt_d;
         tag_q         <= tag_d;
         infer_count_q <= infer_count_d;
      end
   end

   net_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (res_t)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_net_infer_seq.sv
// Directed bench for net_infer_seq with a popcount stand-in for the network.
module tb_net_infer_seq;
   import net_infer_seq_pkg::*;

   localparam int SC = 2;
   localparam int NI = NET_INPUTS;
   localparam int NO = NET_OUTPUT_BITS;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [NI-1:0] in_data = '0;

   logic          in_ready, out_valid, busy;
   logic [NI-1:0] net_i;
   logic [NO-1:0] net_o, out_data;
   logic [7:0]    out_tag;
   logic [31:0]   infer_count;

   logic          in_ready_b, out_valid_b, busy_b;
   logic [NI-1:0] net_i_b;
   logic [NO-1:0] net_o_b, out_data_b;
   logic [1:0]    out_tag_b;
   logic [31:0]   infer_count_b;

   assign net_o   = NO'($countones(net_i));
   assign net_o_b = NO'($countones(net_i_b));

   net_infer_seq #(.SETTLE_CYCLES(SC), .FIFO_DEPTH(4), .TAG_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .net_i(net_i), .net_o(net_o), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
      .busy(busy), .infer_count(infer_count)
   );

   net_infer_seq #(.SETTLE_CYCLES(SC), .FIFO_DEPTH(4), .TAG_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_data(in_data), .net_i(net_i_b), .net_o(net_o_b), .out_valid(out_valid_b),
      .out_ready(out_ready), .out_data(out_data_b), .out_tag(out_tag_b),
      .busy(busy_b), .infer_count(infer_count_b)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Image with exactly n bits set, scattered over the frame.
   function automatic logic [NI-1:0] mk_img(input int n);
      logic [NI-1:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r[(i * 37) % NI] = 1'b1;
      return r;
   endfunction

   // Results seen leaving each DUT, as {tag, class}.
   logic [11:0] q1[$];
   logic [5:0]  q2[$];
   logic [NI-1:0] prev_net = '0;
   logic [31:0]   prev_cnt = '0;
   int            stable = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready)   q1.push_back({out_tag, out_data});
         if (out_valid_b && out_ready) q2.push_back({out_tag_b, out_data_b});
         if (net_i == prev_net) stable++;
         else                   stable = 0;
         if (infer_count > prev_cnt)
            check_eq("net_i_stable_before_push", 32'(stable >= SC + 1), 1);
      end else begin
         stable = 0;
      end
      prev_net = net_i;
      prev_cnt = infer_count;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (2) tick();
      q1.delete();
      q2.delete();
      rst_n = 1'b1;
      tick();
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_count", infer_count, 0);
      check_eq("rst_out_tag", out_tag, 0);
      check_eq("rst_out_data", out_data, 0);
      check_eq("rst_net_i", 32'(net_i == '0), 1);
   endtask

   // Offer image with popcount n; returns just after the accepting edge.
   task automatic send(input int n);
      int w;
      w = 0;
      in_data  = mk_img(n);
      in_valid = 1'b1;
      while (!in_ready && w < 100) begin
         tick();
         w++;
      end
      if (!in_ready) check_eq("accept_timeout", 0, 1);
      tick();
   endtask

   task automatic wait_q1(input int n);
      int w;
      w = 0;
      while (q1.size() < n && w < 200) begin
         tick();
         w++;
      end
      check_eq("q1_size", q1.size(), n);
   endtask

   task automatic wait_q2(input int n);
      int w;
      w = 0;
      while (q2.size() < n && w < 200) begin
         tick();
         w++;
      end
      check_eq("q2_size", q2.size(), n);
   endtask

   int acc[6];

   initial begin
      // Single image latency
      out_ready = 1'b1;
      do_reset();
      send(5);
      in_valid = 1'b0;
      check_eq("t1_in_ready_low", in_ready, 0);
      check_eq("t1_net_i", 32'(net_i == mk_img(5)), 1);
      tick();
      tick();
      check_eq("t1_valid_E2", out_valid, 0);
      tick();
      check_eq("t1_valid_E3", out_valid, 1);
      check_eq("t1_data", out_data, 5);
      check_eq("t1_tag", out_tag, 0);
      check_eq("t1_count", infer_count, 1);
      check_eq("t1_in_ready_E3", in_ready, 1);
      check_eq("t1_busy_E3", busy, 1);
      tick();
      check_eq("t1_valid_E4", out_valid, 0);
      check_eq("t1_busy_E4", busy, 0);
      $display("t1 single image: data=%0d tag=%0d", q1.size() > 0 ? q1[0][3:0] : 4'd0, q1.size() > 0 ? q1[0][11:4] : 8'd0);

      // Back-to-back with in_valid held
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         send(k + 1);
         acc[k] = cyc;
      end
      in_valid = 1'b0;
      for (int k = 1; k < 6; k++) check_eq("t2_spacing", acc[k] - acc[k-1], SC + 2);
      begin
         int w;
         w = 0;
         while (infer_count != 6 && w < 50) begin
            tick();
            w++;
         end
      end
      check_eq("t2_count", infer_count, 6);
      check_eq("t2_last_valid", out_valid, 1);
      check_eq("t2_busy_before_pop", busy, 1);
      tick();
      check_eq("t2_busy_after_pop", busy, 0);
      wait_q1(6);
      for (int k = 0; k < q1.size() && k < 6; k++) begin
         check_eq("t2_tag", q1[k][11:4], k);
         check_eq("t2_data", q1[k][3:0], k + 1);
         $display("t2 result %0d: tag=%0d data=%0d", k, q1[k][11:4], q1[k][3:0]);
      end

      // Backpressure with a full FIFO
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) send(k + 1);
      in_valid = 1'b0;
      repeat (5) tick();
      check_eq("t3_stall_in_ready", in_ready, 0);
      check_eq("t3_stall_count", infer_count, 4);
      check_eq("t3_head_valid", out_valid, 1);
      check_eq("t3_head_tag", out_tag, 0);
      check_eq("t3_head_data", out_data, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("t3_pushpop_count", infer_count, 5);
      check_eq("t3_pushpop_in_ready", in_ready, 1);
      check_eq("t3_pushpop_head_tag", out_tag, 1);
      check_eq("t3_popped", q1.size(), 1);
      send(6);
      in_valid = 1'b0;
      repeat (5) tick();
      check_eq("t3_stall2_count", infer_count, 5);
      check_eq("t3_stall2_in_ready", in_ready, 0);
      out_ready = 1'b1;
      wait_q1(6);
      check_eq("t3_final_count", infer_count, 6);
      for (int k = 0; k < q1.size() && k < 6; k++) begin
         check_eq("t3_tag", q1[k][11:4], k);
         check_eq("t3_data", q1[k][3:0], k + 1);
         $display("t3 result %0d: tag=%0d data=%0d", k, q1[k][11:4], q1[k][3:0]);
      end

      // Tag wrap on the 2-bit-tag instance
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) send(k + 3);
      in_valid = 1'b0;
      wait_q2(5);
      for (int k = 0; k < q2.size() && k < 5; k++) begin
         check_eq("t4_tag", q2[k][5:4], k % 4);
         check_eq("t4_data", q2[k][3:0], k + 3);
         $display("t4 result %0d: tag=%0d data=%0d", k, q2[k][5:4], q2[k][3:0]);
      end

      // Asynchronous reset in the middle of SETTLE
      do_reset();
      out_ready = 1'b1;
      send(9);
      in_valid = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t5_net_i_cleared", 32'(net_i == '0), 1);
      check_eq("t5_out_valid", out_valid, 0);
      check_eq("t5_count", infer_count, 0);
      check_eq("t5_busy", busy, 0);
      tick();
      rst_n = 1'b1;
      q1.delete();
      q2.delete();
      tick();
      send(4);
      in_valid = 1'b0;
      wait_q1(1);
      if (q1.size() > 0) begin
         check_eq("t5_tag_after_reset", q1[0][11:4], 0);
         check_eq("t5_data_after_reset", q1[0][3:0], 4);
         $display("t5 result: tag=%0d data=%0d", q1[0][11:4], q1[0][3:0]);
      end

      // in_data wiggling while not ready is ignored
      do_reset();
      out_ready = 1'b1;
      send(7);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data = mk_img(12 + i);
         tick();
         check_eq("t6_net_i_held", 32'(net_i == mk_img(7)), 1);
      end
      wait_q1(1);
      if (q1.size() > 0) begin
         check_eq("t6_data", q1[0][3:0], 7);
         check_eq("t6_tag", q1[0][11:4], 0);
         $display("t6 result: tag=%0d data=%0d", q1[0][11:4], q1[0][3:0]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/net_infer_seq.md
Name: net_infer_seq

Overview:
- Sequencer for the combinational logic-gate network `top`, which maps NET_I[NET_INPUTS-1:0] to NET_O[NET_OUTPUT_BITS-1:0].
- Accepts binarized 20x20 images over a valid/ready stream and registers each image onto the network inputs.
- Waits a programmable number of settle cycles, then captures the network output into a small result FIFO.
- Emits each result with a sequence tag over a valid/ready stream. Sits between the image loader and the result consumer/UART.

Parameters:
- SETTLE_CYCLES, 2, cycles net_i is held stable before capture; legal range 1..255.
- FIFO_DEPTH, 4, result FIFO entries; power of two, >=2.
- TAG_W, 8, width of the per-image sequence tag; wraps modulo 2^TAG_W.

Ports:
- clk  in  1  single clock domain
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  image available
- in_ready  out  1  sequencer can accept an image
- in_data  in  NET_INPUTS  binarized image
- net_i  out  NET_INPUTS  registered drive to the network NET_I
- net_o  in  NET_OUTPUT_BITS  network NET_O (combinational from net_i)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  NET_OUTPUT_BITS  captured result
- out_tag  out  TAG_W  sequence tag of that result
- busy  out  1  state != IDLE or FIFO non-empty
- infer_count  out  32  total results pushed; saturates at 2^32-1

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, net_i=0, cnt=0, FIFO empty, out_valid=0, out_data=0, out_tag=0, next tag=0, infer_count=0, busy=0.
  - in_ready reads 1 after reset.
  - Reset mid-SETTLE or mid-CAPTURE discards the in-flight image and all queued results.
- FSM states: IDLE, SETTLE, CAPTURE.
  - IDLE: in_ready=1. On in_valid&&in_ready at an edge: net_i<=in_data, cnt<=SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: in_ready=0. If cnt==0, go to CAPTURE; else cnt<=cnt-1. SETTLE lasts exactly SETTLE_CYCLES cycles.
  - CAPTURE: in_ready=0. If push_ok: push {tag, net_o}, tag<=tag+1, infer_count++ (saturating), go to IDLE. Otherwise stay in CAPTURE with net_i held.
- push_ok = !full || (out_valid && out_ready).
  - Simultaneous pop and push on a full FIFO is permitted; occupancy is unchanged.
- Latency, accept at edge E0:
  - Push occurs at edge E(SETTLE_CYCLES+1).
  - With an empty FIFO, out_valid is high from E(SETTLE_CYCLES+1) onward.
  - in_ready returns high at the same edge.
  - Throughput: 1 image per SETTLE_CYCLES+2 cycles.
- net_i holds the last image after capture. It changes only on acceptance (no glitch activity on idle net).
- FIFO:
  - out_data and out_tag show the head entry; they are undefined-but-stable (hold last) when empty.
  - Pop on out_valid&&out_ready.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
- in_data is sampled only on the handshake edge. Changes to in_data while in_ready=0 have no effect.
- The tag wraps from 2^TAG_W-1 to 0.

Decomposition:
- Shared package (alongside NET_INPUTS/NET_OUTPUT_BITS in Globals.sv):
  - seq_state_t enum {IDLE, SETTLE, CAPTURE}.
  - Default constants NET_SETTLE_CYCLES=2 and NET_RES_FIFO_DEPTH=4.
  - typedef net_result_t as a packed struct {tag, class}.
- Sub-module: net_result_fifo, a synchronous FIFO of net_result_t with push/pop/full/empty. The FSM and counters stay in net_infer_seq.

Test Plan:
Bench uses a behavioural net model: net_o = popcount(net_i) truncated to NET_OUTPUT_BITS. It checks that net_i is stable for the SETTLE_CYCLES cycles preceding every push.
- Single image, SETTLE_CYCLES=2, out_ready=1: image with popcount 5 accepted at E0 -> out_valid at E3, out_data=5, out_tag=0, infer_count=1, in_ready high at E3.
- Back-to-back 6 images, out_ready=1, in_valid held: accepts spaced 4 cycles apart; tags 0..5 in order; busy drops 1 cycle after the last pop.
- Backpressure: out_ready=0, 6 images offered, FIFO_DEPTH=4:
  - 4 results queued, the 5th stalls in CAPTURE with in_ready=0.
  - Raise out_ready for 1 cycle -> 5th pushes on the same edge as the pop (full-with-pop).
  - Order preserved.
- Tag wrap, TAG_W=2: 5 images -> tags 0,1,2,3,0.
- Reset mid-SETTLE: assert rst_n=0 asynchronously 1 cycle after accept -> net_i=0, out_valid=0, infer_count=0 immediately. After release the next image gets tag 0.
- in_data toggled while in_ready=0: captured result equals popcount of the image present at the accept edge only.
